// File: rtl/conversor_bcd_bin_2dig.sv
// Two-digit packed-BCD to binary converter using an iterative add-ten loop, with a start/done handshake.
// Optional digit and range validation is compiled in when BCD_CHECK_EN is defined.
module conversor_bcd_bin_2dig #(
    parameter int unsigned N       = 7,
    parameter int unsigned MAX_VAL = 99
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   data_BCD,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [N-1:0] data_bin
);

    localparam int unsigned DW  = 4;
    localparam int unsigned AW  = 8;
    localparam logic [AW-1:0] MAX_ACC  = AW'(MAX_VAL);
    localparam logic [AW-1:0] TEN      = AW'(10);
    localparam logic [DW-1:0] MAX_DIG  = DW'(9);

`ifdef BCD_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ACC   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   d1;
    logic [DW-1:0]   d0;
    logic [AW-1:0]   acc;
    logic [DW-1:0]   cnt;
    logic            err_f;

    logic            busy_nxt;
    logic            done_nxt;
    logic            err_nxt;
    logic [N-1:0]    bin_nxt;

    logic            digit_bad_c;
    logic            range_bad_c;
    logic            cnt_zero_c;

    assign digit_bad_c = CHECK_EN && ((d1 > MAX_DIG) || (d0 > MAX_DIG));
    assign range_bad_c = CHECK_EN && (acc > MAX_ACC);
    assign cnt_zero_c  = (cnt == DW'(0));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CHECK;
            S_CHECK: state_nxt = digit_bad_c ? S_DONE : S_ACC;
            S_ACC:   if (cnt_zero_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
        bin_nxt  = data_bin;
        err_nxt  = err_f;
        case (state)
            S_CHECK: begin
                if (digit_bad_c) err_nxt = 1'b1;
            end
            S_ACC: begin
                if (cnt_zero_c) begin
                    if (range_bad_c) begin
                        err_nxt = 1'b1;
                    end else begin
                        bin_nxt = N'(acc);
                        err_nxt = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered handshake and result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err_f    <= 1'b0;
            data_bin <= '0;
        end else begin
            busy     <= busy_nxt;
            done     <= done_nxt;
            err_f    <= err_nxt;
            data_bin <= bin_nxt;
        end
    end

    // Without validation the flag never sets; the output is forced low regardless
    assign error = err_f & CHECK_EN;

    // Digit capture and add-ten accumulation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d1  <= '0;
            d0  <= '0;
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        d1 <= data_BCD[7:4];
                        d0 <= data_BCD[3:0];
                    end
                end
                S_CHECK: begin
                    if (!digit_bad_c) begin
                        acc <= AW'(d0);
                        cnt <= d1;
                    end
                end
                S_ACC: begin
                    if (!cnt_zero_c) begin
                        acc <= acc + TEN;
                        cnt <= cnt - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bcd_bin_2dig.sv
// Scoreboard bench for conversor_bcd_bin_2dig: two instances (MAX_VAL 99 and 59), directed vectors.
// Expectations follow BCD_CHECK_EN when it is defined for the build.
module tb_conversor_bcd_bin_2dig;

    localparam int unsigned N = 7;

    typedef struct {
        logic [N-1:0] bin;
        logic         err;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_a, start_b;
    logic [7:0]   bcd_a, bcd_b;
    logic         busy_a, done_a, error_a;
    logic         busy_b, done_b, error_b;
    logic [N-1:0] bin_a, bin_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   dones_a = 0;
    int   rises_a = 0;
    int   rise_a = 0, rise_b = 0;
    logic busy_pa = 1'b0, busy_pb = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conversor_bcd_bin_2dig #(.N(N), .MAX_VAL(99)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .data_BCD(bcd_a),
        .busy(busy_a), .done(done_a), .error(error_a), .data_bin(bin_a)
    );

    conversor_bcd_bin_2dig #(.N(N), .MAX_VAL(59)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .data_BCD(bcd_b),
        .busy(busy_b), .done(done_b), .error(error_b), .data_bin(bin_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for instance a: latency measured from the edge where busy rises
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy_a && !busy_pa) begin
                rise_a = cyc;
                rises_a++;
            end
            busy_pa = busy_a;
            if (done_a) begin
                dones_a++;
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_done: done with empty scoreboard, data_bin=%0d", bin_a);
                end else begin
                    e = q_a.pop_front();
                    chk("a_data_bin", int'(bin_a), int'(e.bin));
                    chk("a_error", int'(error_a), int'(e.err));
                    chk("a_latency", cyc - rise_a, e.lat);
                end
            end
        end
    end

    // Monitor for instance b
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy_b && !busy_pb) rise_b = cyc;
            busy_pb = busy_b;
            if (done_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_done: done with empty scoreboard, data_bin=%0d", bin_b);
                end else begin
                    e = q_b.pop_front();
                    chk("b_data_bin", int'(bin_b), int'(e.bin));
                    chk("b_error", int'(error_b), int'(e.err));
                    chk("b_latency", cyc - rise_b, e.lat);
                end
            end
        end
    end

    // Called just after a rising edge; waits for idle, pulses start for one cycle
    task automatic issue(input bit to_b, input logic [7:0] bcd,
                         input int bin, input bit err, input int lat);
        int n;
        exp_t e;
        n = 0;
        while ((to_b ? busy_b : busy_a) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still high after %0d cycles", n);
        end
        e.bin = N'(bin);
        e.err = err;
        e.lat = lat;
        if (to_b) begin
            bcd_b = bcd; start_b = 1'b1; q_b.push_back(e);
        end else begin
            bcd_a = bcd; start_a = 1'b1; q_a.push_back(e);
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d/%0d results still pending", q_a.size(), q_b.size());
        end
    endtask

    initial begin
        exp_t e;
        int   d0, r0, n;
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        bcd_a   = 8'h00;
        bcd_b   = 8'h00;
        #1;
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_done", int'(done_a), 0);
        chk("reset_error", int'(error_a), 0);
        chk("reset_data_bin", int'(bin_a), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, 8'h47, 47, 1'b0, 6);
        issue(1'b0, 8'h00, 0, 1'b0, 2);
        issue(1'b0, 8'h99, 99, 1'b0, 11);
`ifdef BCD_CHECK_EN
        issue(1'b0, 8'h3A, 99, 1'b1, 1);
        issue(1'b0, 8'h0F, 99, 1'b1, 1);
`else
        issue(1'b0, 8'h3A, 40, 1'b0, 5);
        issue(1'b0, 8'h0F, 15, 1'b0, 2);
`endif
        issue(1'b0, 8'h05, 5, 1'b0, 2);

        issue(1'b1, 8'h12, 12, 1'b0, 3);
`ifdef BCD_CHECK_EN
        issue(1'b1, 8'h60, 12, 1'b1, 8);
`else
        issue(1'b1, 8'h60, 60, 1'b0, 8);
`endif
        issue(1'b1, 8'h59, 59, 1'b0, 7);
        wait_drain();

        // start held high: exactly three back-to-back conversions, none accepted while busy
        e.bin = N'(21);
        e.err = 1'b0;
        e.lat = 4;
        for (int i = 0; i < 3; i++) q_a.push_back(e);
        d0 = dones_a;
        r0 = rises_a;
        bcd_a = 8'h21;
        start_a = 1'b1;
        n = 0;
        while (dones_a < d0 + 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        start_a = 1'b0;
        chk("held_done_count", dones_a - d0, 3);
        chk("held_accept_count", rises_a - r0, 3);
        wait_drain();

        // Reset during ACC of 0x85 aborts without a done pulse
        issue(1'b0, 8'h85, 85, 1'b0, 10);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        q_a.delete();
        #1;
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_error", int'(error_a), 0);
        chk("abort_data_bin", int'(bin_a), 0);
        chk("abort_b_data_bin", int'(bin_b), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        e.bin = N'(85);
        e.err = 1'b0;
        e.lat = 10;
        q_a.push_back(e);
        bcd_a = 8'h85;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("accept_after_reset", int'(busy_a), 1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
